// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order and the
// active-high hex glyph table (bit 0 = segment a, bit 6 = segment g).
package seven_segment_scanner_pkg;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam int SEG_W = SEG_G - SEG_A + 1;

  // Index 0..15 maps to the hex digit 0..F, encoded {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] GLYPHS [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/seven_segment_scanner_glyph.sv
// Combinational hex-to-seven-segment lookup, active-high {g,f,e,d,c,b,a}.
module hex_glyph
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] glyph
);

  assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver: holding register, refresh prescaler,
// digit scan, leading-zero suppression and output polarity, all outputs registered.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int   PW  = $clog2(REFRESH_DIV);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] held_value;
  logic [NUM_DIGITS-1:0]   held_dp;
  logic [NUM_DIGITS-1:0]   held_blank;
  logic                    held_lz;
  logic [PW-1:0]           presc;
  logic [IDX_W-1:0]        scan_idx;
  logic                    wrap;

  assign wrap = (presc == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_value <= '0;
      held_dp    <= '0;
      held_blank <= '0;
      held_lz    <= 1'b0;
    end else if (load) begin
      held_value <= value;
      held_dp    <= dp;
      held_blank <= blank;
      held_lz    <= lz_suppress;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (wrap) begin
      presc <= '0;
      if (scan_idx == IDX_W'(NUM_DIGITS - 1)) scan_idx <= '0;
      else                                    scan_idx <= scan_idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  logic [3:0]            cur_nibble;
  logic [SEG_W-1:0]      cur_glyph;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  upper_zero;
  logic                  dark;
  logic [NUM_DIGITS-1:0] onehot;
  logic [SEG_W-1:0]      seg_hi;
  logic                  dp_hi;
  logic [NUM_DIGITS-1:0] an_hi;

  // upper_zero: the selected nibble and every more-significant one are zero.
  always_comb begin
    cur_nibble = '0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    upper_zero = 1'b1;
    onehot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx) begin
        cur_nibble = held_value[4*i +: 4];
        sel_dp     = held_dp[i];
        sel_blank  = held_blank[i];
        onehot[i]  = 1'b1;
      end
      if (IDX_W'(i) >= scan_idx && held_value[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  hex_glyph u_glyph (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  always_comb begin
    dark   = sel_blank || (held_lz && scan_idx != '0 && upper_zero);
    seg_hi = dark ? '0 : cur_glyph;
    dp_hi  = !dark && sel_dp;
    an_hi  = dark ? '0 : onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg       <= {SEG_W{INV}};
      dp_out    <= INV;
      an        <= {NUM_DIGITS{INV}};
      digit_idx <= '0;
    end else begin
      seg       <= seg_hi ^ {SEG_W{INV}};
      dp_out    <= dp_hi ^ INV;
      an        <= an_hi ^ {NUM_DIGITS{INV}};
      digit_idx <= scan_idx;
    end
  end

endmodule
